// File: rtl/lag_correlator_pkg.sv
// Shared constants, word-count derivations and readout state for the
// multi-lag correlator.
package correlator_pkg;

    localparam int MODE_UNSIGNED = 0;
    localparam int MODE_SIGN     = 1;

    typedef enum logic {
        RD_IDLE,
        RD_SEND
    } rd_state_e;

    function automatic int num_baselines(int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int num_words(int n, int lags);
        return num_baselines(n) * lags + n;
    endfunction

    // Row-major position of pair (i,j), i<j, among all baselines
    function automatic int baseline_idx(int i, int j, int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/lag_correlator_if.sv
// Frame readout stream: one correlator word per valid/ready transfer.
interface lag_correlator_if #(
    parameter int RESOLUTION = 32
);
    logic [RESOLUTION-1:0] out_data;
    logic [15:0]           out_index;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  saturated;

    modport master (
        output out_data, out_index, out_valid, out_last, saturated,
        input  out_ready
    );

    modport slave (
        input  out_data, out_index, out_valid, out_last, saturated,
        output out_ready
    );
endinterface

// File: rtl/lag_correlator_acc.sv
// One correlator word: term generator feeding a saturating accumulator
// with a sticky per-frame clip flag.
module lag_accumulator
    import correlator_pkg::*;
#(
    parameter int ADC_RESOLUTION = 8,
    parameter int RESOLUTION     = 32,
    parameter int MODE           = MODE_UNSIGNED,
    parameter bit IS_AUTO        = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      accept_i,
    input  logic                      clear_i,
    input  logic [ADC_RESOLUTION-1:0] a_i,
    input  logic [ADC_RESOLUTION-1:0] b_i,
    output logic [RESOLUTION-1:0]     res_o,
    output logic                      clip_o
);

    localparam int TW = 2 * ADC_RESOLUTION;
    localparam int SW = ((RESOLUTION > TW) ? RESOLUTION : TW) + 1;
    localparam logic [RESOLUTION-1:0] MAXV = '1;

    logic [TW-1:0]         prod;
    logic [TW-1:0]         term;
    logic                  match;
    logic [SW-1:0]         sum;
    logic                  clamp;
    logic [RESOLUTION-1:0] acc_q, acc_d;
    logic                  clip_q, clip_d;

    assign prod  = TW'(a_i) * TW'(b_i);
    assign match = a_i[ADC_RESOLUTION-1] ~^ b_i[ADC_RESOLUTION-1];

    always_comb begin
        term = prod;
        if (MODE == MODE_SIGN) begin
            term = IS_AUTO ? TW'(a_i[ADC_RESOLUTION-1]) : TW'(match);
        end else if (IS_AUTO) begin
            term = TW'(a_i);
        end
    end

    // Result including the current sample, used both to accumulate and to snapshot
    always_comb begin
        sum    = SW'(acc_q) + SW'(term);
        clamp  = (sum > SW'(MAXV));
        res_o  = clamp ? MAXV : sum[RESOLUTION-1:0];
        clip_o = clip_q | clamp;
    end

    always_comb begin
        acc_d  = acc_q;
        clip_d = clip_q;
        if (accept_i) begin
            if (clear_i) begin
                acc_d  = '0;
                clip_d = 1'b0;
            end else begin
                acc_d  = res_o;
                clip_d = clip_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            clip_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            clip_q <= clip_d;
        end
    end

endmodule

// File: rtl/lag_correlator.sv
// Multi-lag correlator: delay lines, per-word accumulators, frame
// buffer and a valid/ready readout of the finished frame.
module lag_correlator
    import correlator_pkg::*;
#(
    parameter int NUM_INPUTS     = 4,
    parameter int ADC_RESOLUTION = 8,
    parameter int RESOLUTION     = 32,
    parameter int NUM_LAGS       = 4,
    parameter int MODE           = MODE_UNSIGNED
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_INPUTS*ADC_RESOLUTION-1:0] in,
    input  logic                                 sample_pulse,
    input  logic                                 enable,
    input  logic [31:0]                          integration_samples,
    lag_correlator_if.master                     rd,
    output logic                                 frame_overrun
);

    localparam int NB = num_baselines(NUM_INPUTS);
    localparam int NW = num_words(NUM_INPUTS, NUM_LAGS);
    localparam int NS = (NUM_LAGS > 1) ? NUM_LAGS - 1 : 1;
    localparam int IW = $clog2(NW);

    typedef logic [ADC_RESOLUTION-1:0] smp_t;

    smp_t x     [NUM_INPUTS];
    smp_t dly_q [NUM_INPUTS][NS];
    smp_t tap   [NUM_INPUTS][NUM_LAGS];

    logic        accept;
    logic        frame_end;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] eff_n;
    logic [32:0] cnt_inc;

    logic [RESOLUTION-1:0] acc_res [NW];
    logic [NW-1:0]         clip_res;

    assign accept    = sample_pulse & enable;
    assign eff_n     = (integration_samples == 32'd0) ? 32'd1 : integration_samples;
    assign cnt_inc   = {1'b0, cnt_q} + 33'd1;
    assign frame_end = accept && (cnt_inc >= {1'b0, eff_n});
    assign cnt_d     = frame_end ? 32'd0 : (accept ? cnt_inc[31:0] : cnt_q);

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        assign x[i] = in[i*ADC_RESOLUTION +: ADC_RESOLUTION];
        for (genvar s = 0; s < NS; s++) begin : g_stage
            if (NUM_LAGS == 1) begin : g_none
                assign dly_q[i][s] = '0;
            end else if (s == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n)      dly_q[i][s] <= '0;
                    else if (accept) dly_q[i][s] <= x[i];
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n)      dly_q[i][s] <= '0;
                    else if (accept) dly_q[i][s] <= dly_q[i][s-1];
                end
            end
        end
        for (genvar k = 0; k < NUM_LAGS; k++) begin : g_tap
            if (k == 0) begin : g_cur
                assign tap[i][k] = x[i];
            end else begin : g_old
                assign tap[i][k] = dly_q[i][k-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_row
        for (genvar j = i + 1; j < NUM_INPUTS; j++) begin : g_col
            for (genvar k = 0; k < NUM_LAGS; k++) begin : g_lag
                localparam int W = baseline_idx(i, j, NUM_INPUTS) * NUM_LAGS + k;
                lag_accumulator #(
                    .ADC_RESOLUTION (ADC_RESOLUTION),
                    .RESOLUTION     (RESOLUTION),
                    .MODE           (MODE),
                    .IS_AUTO        (1'b0)
                ) u_acc (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .accept_i (accept),
                    .clear_i  (frame_end),
                    .a_i      (x[i]),
                    .b_i      (tap[j][k]),
                    .res_o    (acc_res[W]),
                    .clip_o   (clip_res[W])
                );
            end
        end
        lag_accumulator #(
            .ADC_RESOLUTION (ADC_RESOLUTION),
            .RESOLUTION     (RESOLUTION),
            .MODE           (MODE),
            .IS_AUTO        (1'b1)
        ) u_auto (
            .clk      (clk),
            .rst_n    (rst_n),
            .accept_i (accept),
            .clear_i  (frame_end),
            .a_i      (x[i]),
            .b_i      (x[i]),
            .res_o    (acc_res[NB*NUM_LAGS+i]),
            .clip_o   (clip_res[NB*NUM_LAGS+i])
        );
    end

    rd_state_e             state_q;
    logic [RESOLUTION-1:0] buf_q [NW];
    logic [RESOLUTION-1:0] data_q;
    logic [15:0]           idx_q;
    logic [15:0]           nxt;
    logic                  valid_q, last_q, sat_q, ovr_q;
    logic                  xfer, fin, load;

    assign nxt  = idx_q + 16'd1;
    assign xfer = valid_q && rd.out_ready;
    assign fin  = xfer && (idx_q == 16'(NW - 1));
    // A finished frame is only taken when the buffer is free or freeing now
    assign load = frame_end && ((state_q == RD_IDLE) || fin);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
            for (int w = 0; w < NW; w++) buf_q[w] <= '0;
        end else begin
            ovr_q <= frame_end && !load;
            if (load) begin
                state_q <= RD_SEND;
                for (int w = 0; w < NW; w++) buf_q[w] <= acc_res[w];
                idx_q   <= '0;
                data_q  <= acc_res[0];
                valid_q <= 1'b1;
                last_q  <= (NW == 1);
                sat_q   <= |clip_res;
            end else if (fin) begin
                state_q <= RD_IDLE;
                idx_q   <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (xfer) begin
                idx_q  <= nxt;
                data_q <= buf_q[nxt[IW-1:0]];
                last_q <= (nxt == 16'(NW - 1));
            end
        end
    end

    assign rd.out_data    = data_q;
    assign rd.out_index   = idx_q;
    assign rd.out_valid   = valid_q;
    assign rd.out_last    = last_q;
    assign rd.saturated   = sat_q;
    assign frame_overrun  = ovr_q;

endmodule

// File: doc/lag_correlator.md
# lag_correlator

Parametrised multi-lag correlator core for the interferometer datapath, the successor to the zero-lag pairwise pulse-counter array. It accumulates every baseline (i<j) at NUM_LAGS sample delays, plus one auto term per input, over a programmable number of samples. It snapshots the finished frame into a holding buffer and streams it out word-by-word over a valid/ready interface to the UART transmitter. Accumulators saturate instead of wrapping and are flagged when they do. The core supports two product modes: full magnitude and 1-bit sign correlation.

## Interface
- NUM_INPUTS, 4: antenna channels (≥2)
- ADC_RESOLUTION, 8: bits per sample, offset-binary
- RESOLUTION, 32: accumulator and output word width
- NUM_LAGS, 4: lags 0..NUM_LAGS-1 per baseline (≥1)
- MODE, 0: 0 = unsigned product; 1 = sign-bit (MSB XNOR) correlation
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- in  in  NUM_INPUTS*ADC_RESOLUTION  channel i at [i*ADC_RESOLUTION +: ADC_RESOLUTION]
- sample_pulse  in  1  one-cycle strobe, accept one sample set
- enable  in  1  accept samples when high
- integration_samples  in  32  samples per frame; 0 treated as 1
- out_data  out  RESOLUTION  current word
- out_index  out  16  word index within frame
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word
- out_last  out  1  high with final word of frame
- saturated  out  1  frame being read contains ≥1 clipped word
- frame_overrun  out  1  one-cycle pulse, completed frame dropped

## Operation
- Word count: NUM_WORDS = NUM_BASELINES*NUM_LAGS + NUM_INPUTS, where NUM_BASELINES = NUM_INPUTS*(NUM_INPUTS-1)/2.
- Word order:
  - Baselines in order (0,1),(0,2)…(0,N-1),(1,2)…; within each baseline, lag 0 first. Word index = b*NUM_LAGS + k.
  - Autos follow at index NUM_BASELINES*NUM_LAGS + i.
- Accepted sample: sample_pulse & enable. All other cycles leave the delay lines, accumulators and sample counter unchanged.
- Delay line: per input, NUM_LAGS-1 stages. Shifts on each accepted sample and resets to 0.
- Baseline (i,j) lag k term: in_i(current) × in_j delayed by k accepted samples. The term uses pre-shift values.
  - MODE 0: unsigned product, 2*ADC_RESOLUTION bits.
  - MODE 1: 1 if the MSBs of the two operands are equal, else 0.
- Auto term i: MODE 0 adds in_i; MODE 1 adds the MSB of in_i.
- Accumulate: acc + term, clamped to all-ones. A clamp sets the frame's sticky clip flag.
- Frame end: sample counter + 1 ≥ integration_samples on an accepted sample. That sample is included, then:
  - the accumulator results (including the final sample) are copied to the frame buffer;
  - the clip flag is copied to the frame buffer;
  - accumulators, counter and clip flag are cleared.
- Readout FSM IDLE/SEND:
  - IDLE: a snapshot loads the buffer, sets index 0 and moves to SEND.
  - SEND: out_valid=1. A transfer (valid&ready) increments the index. The transfer at NUM_WORDS-1 returns to IDLE.
- Snapshot while in SEND with no final transfer that cycle: the new frame is discarded, the buffer is unchanged and frame_overrun pulses. Accumulators still clear.
- Snapshot in the same cycle as the final transfer: accepted, no overrun; the FSM stays in SEND with index 0.
- enable low: sampling freezes; readout continues unaffected.
- integration_samples is compared live. Lowering it below the current count ends the frame on the next accepted sample.

## Timing
- Reset values: all outputs 0; FSM IDLE; accumulators, delay lines and counter 0.
- Accumulators update at the clock edge where the sample is accepted; no pipeline stage.
- Snapshot on edge t gives out_valid=1, out_index=0 and out_data=word 0 after edge t.
- out_data, out_index, out_last and saturated are registered. They are stable while out_valid & !out_ready.
- Throughput: one word per cycle when out_ready is held high.
- A reset mid-frame or mid-readout takes effect on the next edge. Partial data is lost and no overrun is signalled.

## Structure
- Shared package correlator_pkg holds:
  - NUM_BASELINES and NUM_WORDS derivations;
  - a baseline-index function (i,j)→b;
  - the MODE constants.
- Sub-module lag_accumulator: one term generator plus saturating accumulator with clip flag, instantiated once per word.
- The top level contains the delay lines, sample counter, frame buffer and readout FSM.

## Test plan
All scenarios use NUM_INPUTS=2, NUM_LAGS=2, RESOLUTION=16 (4 words) unless stated.
1. Constant in0=3, in1=5, integration_samples=4, 4 pulses, ready high -> words 60, 45, 12, 20; out_last on index 3; saturated=0.
2. in0=in1=255, integration_samples=2 -> word 0 = 65535, saturated=1, autos = 510.
3. out_ready=0, integration_samples=1, two pulses -> first frame held intact; frame_overrun pulses one cycle on the second pulse.
4. Second snapshot coincident with the final transfer -> no overrun; index 0 valid on the next cycle with the new data.
5. MODE=1, in0=0x80, in1=0x7F, 3 pulses -> words 0, 0, 3, 0.
6. Behaviour under enable and reset:
   - enable=0 with 10 pulses -> no frame.
   - rst_n low during readout at index 2 -> out_valid=0 and out_index=0 on the next cycle.
